// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one main-memory port between the I-cache and D-cache.
// One arbitration cycle in IDLE, then the owner's request is passed straight through.
module mem_arbiter #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_busy,
    output logic              arb_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_req_i;
    logic   w_req_d;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        arb_busy    = 1'b0;
        arb_owner   = r_last;
        case (r_state)
            IDLE: begin
                // On a tie, D wins under fixed priority or when I was served last.
                if (w_req_i && w_req_d)
                    w_state_nxt = ((PRIO_MODE != 0) || !r_last) ? GRANT_D : GRANT_I;
                else if (w_req_i)
                    w_state_nxt = GRANT_I;
                else if (w_req_d)
                    w_state_nxt = GRANT_D;
            end
            GRANT_I: begin
                arb_busy  = 1'b1;
                arb_owner = 1'b0;
                mem_write = i_write;
                mem_read  = i_read & ~i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                if (!w_req_i) begin
                    w_state_nxt = IDLE;
                end else if (mem_ready) begin
                    i_ready     = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                arb_busy  = 1'b1;
                arb_owner = 1'b1;
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                if (!w_req_d) begin
                    w_state_nxt = IDLE;
                end else if (mem_ready) begin
                    d_ready     = 1'b1;
                    w_last_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances share the cache-side stimulus;
// expected grants are queued when requests are driven and checked as each grant appears.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0, mem_rdata = '0;
    logic          mem_ready0 = 1'b0, mem_ready1 = 1'b0;

    logic [DW-1:0] i_rdata0, d_rdata0, mem_wdata0, i_rdata1, d_rdata1, mem_wdata1;
    logic [AW-1:0] mem_addr0, mem_addr1;
    logic          i_ready0, d_ready0, mem_read0, mem_write0, busy0, owner0;
    logic          i_ready1, d_ready1, mem_read1, mem_write1, busy1, owner1;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic          owner;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    grant_t q0[$];
    grant_t q1[$];
    logic   mon0_en = 1'b0, mon1_en = 1'b0;
    logic   prev0 = 1'b0, prev1 = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata0), .i_ready(i_ready0),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata0), .d_ready(d_ready0),
        .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ready(mem_ready0),
        .arb_busy(busy0), .arb_owner(owner0)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata1), .i_ready(i_ready1),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata), .mem_ready(mem_ready1),
        .arb_busy(busy1), .arb_owner(owner1)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic grant_t mk(input logic own, input logic wr, input logic [AW-1:0] a,
                                  input logic [DW-1:0] wd);
        grant_t g;
        g.owner = own;
        g.wr    = wr;
        g.addr  = a;
        g.wdata = wd;
        return g;
    endfunction

    // Scoreboard: each new grant (busy rising) must match the oldest queued expectation.
    always @(negedge clk) begin
        grant_t e;
        if (mon0_en && busy0 && !prev0) begin
            if (q0.size() == 0) check_val("grant0_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                check_val("grant0_owner", owner0, e.owner);
                check_val("grant0_write", mem_write0, e.wr);
                check_val("grant0_read", mem_read0, !e.wr);
                check_val("grant0_addr", mem_addr0, e.addr);
                if (e.wr) check_val("grant0_wdata", mem_wdata0, e.wdata);
            end
        end
        if (mon1_en && busy1 && !prev1) begin
            if (q1.size() == 0) check_val("grant1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                check_val("grant1_owner", owner1, e.owner);
                check_val("grant1_write", mem_write1, e.wr);
                check_val("grant1_addr", mem_addr1, e.addr);
            end
        end
        prev0 <= busy0;
        prev1 <= busy1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        {i_read, i_write, d_read, d_write} = 4'b0;
        mem_ready0 = 1'b0;
        mem_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input bit sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? busy1 : busy0) && n < 30);
        check_val("grant_wait", sel ? busy1 : busy0, 1);
    endtask

    // Called at the negedge of a grant cycle: return ready after lat cycles, check the pulse
    // and the following mandatory idle cycle.
    task automatic complete(input bit sel, input int lat, input logic [DW-1:0] data, input bit drop);
        logic own;
        own = sel ? owner1 : owner0;
        repeat (lat) @(posedge clk);
        #1;
        if (sel) mem_ready1 = 1'b1; else mem_ready0 = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        if (sel) begin
            check_val("owner_ready", own ? d_ready1 : i_ready1, 1);
            check_val("other_ready", own ? i_ready1 : d_ready1, 0);
            check_val("rdata", own ? d_rdata1 : i_rdata1, data);
        end else begin
            check_val("owner_ready", own ? d_ready0 : i_ready0, 1);
            check_val("other_ready", own ? i_ready0 : d_ready0, 0);
            check_val("rdata", own ? d_rdata0 : i_rdata0, data);
        end
        @(posedge clk);
        #1;
        mem_ready0 = 1'b0;
        mem_ready1 = 1'b0;
        if (drop) begin
            if (own) {d_read, d_write} = 2'b0;
            else     {i_read, i_write} = 2'b0;
        end
        @(negedge clk);
        check_val("idle_gap", sel ? busy1 : busy0, 0);
    endtask

    initial begin
        logic [DW-1:0] pat_a, pat_1, pat_5, pat_2;
        pat_a = {32{4'hA}};
        pat_1 = {32{4'h1}};
        pat_5 = {32{4'h5}};
        pat_2 = {32{4'h2}};

        // Reset state
        mon0_en = 1'b1;
        do_reset();
        @(negedge clk);
        check_val("rst_owner", owner0, 1);
        check_val("rst_busy", busy0, 0);
        check_val("rst_memrd", mem_read0, 0);
        check_val("rst_memwr", mem_write0, 0);
        check_val("rst_addr", mem_addr0, 0);
        check_val("rst_ready", {i_ready0, d_ready0}, 0);

        // Single I read
        @(posedge clk);
        #1;
        i_read = 1'b1;
        i_addr = 28'h0000010;
        q0.push_back(mk(0, 0, 28'h0000010, '0));
        @(negedge clk);
        check_val("arb_cycle_rd", mem_read0, 0);
        wait_busy(0);
        complete(0, 3, pat_a, 1);

        // Round-robin ties from reset: I, D, I
        do_reset();
        i_read = 1'b1; i_addr = 28'h20;
        d_read = 1'b1; d_addr = 28'h30;
        q0.push_back(mk(0, 0, 28'h20, '0));
        q0.push_back(mk(1, 0, 28'h30, '0));
        q0.push_back(mk(0, 0, 28'h20, '0));
        wait_busy(0); complete(0, 1, 128'h11, 0);
        wait_busy(0); complete(0, 2, 128'h22, 0);
        wait_busy(0); complete(0, 1, 128'h33, 1);
        d_read = 1'b0;

        // D write-back, I read arrives mid-grant, then D refill
        d_write = 1'b1; d_addr = 28'h0000123; d_wdata = pat_1;
        q0.push_back(mk(1, 1, 28'h0000123, pat_1));
        q0.push_back(mk(0, 0, 28'h40, '0));
        q0.push_back(mk(1, 0, 28'h0000456, '0));
        wait_busy(0);
        i_read = 1'b1; i_addr = 28'h40;
        complete(0, 2, 128'h0, 1);
        d_read = 1'b1; d_addr = 28'h0000456;
        wait_busy(0); complete(0, 2, 128'hBBBB, 1);
        wait_busy(0); complete(0, 2, 128'hCCCC, 1);

        // Read and write together forwards as a write
        i_read = 1'b1; i_write = 1'b1; i_addr = 28'h88; i_wdata = pat_2;
        q0.push_back(mk(0, 1, 28'h88, pat_2));
        wait_busy(0); complete(0, 1, 128'h0, 1);

        // Abort with a coincident then stray ready
        d_read = 1'b1; d_addr = 28'h77;
        q0.push_back(mk(1, 0, 28'h77, '0));
        wait_busy(0);
        @(posedge clk);
        #1;
        d_read = 1'b0;
        mem_ready0 = 1'b1;
        @(negedge clk);
        check_val("abort_strobe", mem_read0, 0);
        check_val("abort_noready", d_ready0, 0);
        @(negedge clk);
        check_val("abort_idle", busy0, 0);
        check_val("stray_ready", {i_ready0, d_ready0}, 0);
        mem_ready0 = 1'b0;

        // Reset during GRANT_D clears outputs without waiting for a clock
        d_write = 1'b1; d_addr = 28'h99; d_wdata = pat_5;
        q0.push_back(mk(1, 1, 28'h99, pat_5));
        wait_busy(0);
        mem_ready0 = 1'b1;
        #1;
        check_val("pre_rst_ready", d_ready0, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_memwr", mem_write0, 0);
        check_val("rst_mid_ready", d_ready0, 0);
        check_val("rst_mid_busy", busy0, 0);
        check_val("rst_mid_owner", owner0, 1);
        d_write = 1'b0;
        mem_ready0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_read = 1'b1; i_addr = 28'hA0;
        d_read = 1'b1; d_addr = 28'hB0;
        q0.push_back(mk(0, 0, 28'hA0, '0));
        q0.push_back(mk(1, 0, 28'hB0, '0));
        wait_busy(0); complete(0, 1, 128'h44, 1);
        wait_busy(0); complete(0, 1, 128'h55, 1);
        check_val("q0_drained", q0.size(), 0);

        // Fixed priority: D wins every tie until it drops its request
        mon0_en = 1'b0;
        do_reset();
        mon1_en = 1'b1;
        i_read = 1'b1; i_addr = 28'h50;
        d_read = 1'b1; d_addr = 28'h60;
        q1.push_back(mk(1, 0, 28'h60, '0));
        q1.push_back(mk(1, 0, 28'h60, '0));
        q1.push_back(mk(1, 0, 28'h60, '0));
        q1.push_back(mk(0, 0, 28'h50, '0));
        wait_busy(1); complete(1, 1, 128'h66, 0);
        wait_busy(1); complete(1, 1, 128'h77, 0);
        wait_busy(1); complete(1, 1, 128'h88, 1);
        wait_busy(1); complete(1, 1, 128'h99, 1);
        check_val("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
